// File: rtl/weight_fetch.sv
// weight_fetch: SRAM read engine that streams a programmed address window (optionally
// repeated) to the PE array through a small credit-controlled FIFO.
module weight_fetch #(
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] len_i,
    input  logic [7:0]        rep_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_cs_o,
    output logic              mem_oe_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_wreq_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              w_valid_o,
    output logic [DATA_W-1:0] w_data_o,
    output logic              w_last_o,
    input  logic              w_ready_i
);

    localparam logic [3:0]        WRITE_DIS = 4'b0000;
    localparam int unsigned       PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned       CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [7:0]        rep_q, rep_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic [7:0]        pass_q, pass_d;
    logic              inflight_q, inflight_d;
    logic              infl_last_q, infl_last_d;

    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic              fifo_last_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic              issue;
    logic              last_word;
    logic              push;
    logic              pop;
    logic              empty;
    logic [CNT_W-1:0]  credit_used;

    assign empty       = (count_q == '0);
    assign push        = inflight_q;
    assign pop         = !empty && w_ready_i;
    // Words held in the FIFO plus the one possibly still coming back from the SRAM.
    assign credit_used = count_q + CNT_W'(inflight_q);
    assign last_word   = (word_q == len_q - ADDR_W'(1));

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        rep_d       = rep_q;
        addr_d      = addr_q;
        word_d      = word_q;
        pass_d      = pass_q;
        issue       = 1'b0;
        done_o      = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    base_d = base_i;
                    len_d  = len_i;
                    rep_d  = rep_i;
                    addr_d = base_i;
                    word_d = '0;
                    pass_d = '0;
                    if (len_i == '0 || rep_i == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                if (credit_used < DEPTH_C) begin
                    issue = 1'b1;
                    if (last_word) begin
                        word_d = '0;
                        addr_d = base_q;
                        pass_d = pass_q + 8'd1;
                        if (pass_q == rep_q - 8'd1) begin
                            state_d = StDrain;
                        end
                    end else begin
                        word_d = word_q + ADDR_W'(1);
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            StDrain: begin
                if (empty && !inflight_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (abort_i) begin
            state_d = StIdle;
            issue   = 1'b0;
            done_o  = 1'b0;
            word_d  = '0;
            pass_d  = '0;
        end

        inflight_d  = issue;
        infl_last_d = issue && last_word;
    end

    assign busy_o      = (state_q != StIdle);
    assign mem_cs_o    = issue;
    assign mem_oe_o    = issue;
    assign mem_addr_o  = issue ? addr_q : '0;
    assign mem_wreq_o  = WRITE_DIS;
    assign mem_wdata_o = '0;

    assign w_valid_o   = !empty;
    assign w_data_o    = empty ? '0 : fifo_data_q[rd_ptr_q];
    assign w_last_o    = empty ? 1'b0 : fifo_last_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            base_q      <= '0;
            len_q       <= '0;
            rep_q       <= '0;
            addr_q      <= '0;
            word_q      <= '0;
            pass_q      <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            rep_q       <= rep_d;
            addr_q      <= addr_d;
            word_q      <= word_d;
            pass_q      <= pass_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= mem_rdata_i;
            fifo_last_q[wr_ptr_q] <= infl_last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || abort_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule
